// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the load/store sequencer.
// Holds the access-size codes, the sequencer state enum and the lane masks
// (right-aligned, shifted into place by the lane aligner).
package mem_access_pkg;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [31:0] BYTE_LANE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_LANE_MASK = 32'h0000_FFFF;
    localparam logic [31:0] WORD_LANE_MASK = 32'hFFFF_FFFF;
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} stateT;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian lane extraction for loads and lane merge for stores.
// Ports: iSize (0 byte, 1 half, 2/3 word), iOffset = addr[1:0], iSigned,
//        iRdWord (word read from DataMem), iWrData (store data, low bytes used),
//        oLoadValue (extracted, extended load result), oStoreWord (merged write word).
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  iSize,
    input  logic [1:0]  iOffset,
    input  logic        iSigned,
    input  logic [31:0] iRdWord,
    input  logic [31:0] iWrData,
    output logic [31:0] oLoadValue,
    output logic [31:0] oStoreWord
);
    logic [4:0]  shift;
    logic [31:0] laneMask;
    logic [15:0] lane;
    always_comb begin
        // Big-endian: offset 0 is the most significant lane, so shift by the inverted offset.
        shift = iSize == SZ_BYTE ? {~iOffset, 3'b000} : iSize == SZ_HALF ? {~iOffset[1], 4'b0000} : 5'd0;
        laneMask = (iSize == SZ_BYTE ? BYTE_LANE_MASK : iSize == SZ_HALF ? HALF_LANE_MASK : WORD_LANE_MASK) << shift;
        lane = 16'(iRdWord >> shift);
        oLoadValue = iSize == SZ_BYTE ? {{24{iSigned & lane[7]}}, lane[7:0]}
                   : iSize == SZ_HALF ? {{16{iSigned & lane[15]}}, lane} : iRdWord;
        oStoreWord = (iRdWord & ~laneMask) | ((iWrData << shift) & laneMask);
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer turning byte/half/word accesses into word DataMem transactions.
// Ports: iClk/iRst (async active-high); request iReq,iWe,iSize,iSigned,iAddr,iWrData;
//        status oBusy,oDone,oRdData,oAlignErr,oTimeout; DataMem side oMemRd,oMemWr,
//        oMemAddr,oMemWrData,iMemRdData,iMemAccessable. WAIT_MAX bounds strobe wait cycles.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq,
    input  logic        iWe,
    input  logic [1:0]  iSize,
    input  logic        iSigned,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWrData,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oRdData,
    output logic        oAlignErr,
    output logic        oTimeout,
    output logic        oMemRd,
    output logic        oMemWr,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWrData,
    input  logic [31:0] iMemRdData,
    input  logic        iMemAccessable
);
    localparam int CW = $clog2(WAIT_MAX + 1);
    stateT state, nextState;
    logic [CW-1:0] waitCnt;
    logic weQ, signedQ, alignErrQ, timeoutQ;
    logic [1:0] sizeQ, offsetQ;
    logic [31:0] wrDataQ, loadValue, mergedWord;
    logic misaligned, waitExpired, strobing;

    // Sizes 2 and 3 both behave as word, so iSize[1] marks a word access.
    assign misaligned = (iSize == SZ_HALF && iAddr[0]) || (iSize[1] && iAddr[1:0] != 2'b00);
    assign strobing = state == RD || state == WR;
    // This wait cycle would be the WAIT_MAX-th consecutive one.
    assign waitExpired = !iMemAccessable && waitCnt == CW'(WAIT_MAX - 1);

    mem_lane_align uAlign (
        .iSize(sizeQ),
        .iOffset(offsetQ),
        .iSigned(signedQ),
        .iRdWord(iMemRdData),
        .iWrData(wrDataQ),
        .oLoadValue(loadValue),
        .oStoreWord(mergedWord)
    );

    always_ff @(posedge iClk or posedge iRst)
        if (iRst) state <= IDLE;
        else state <= nextState;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (iReq) nextState = misaligned ? DONE : (iWe && iSize[1]) ? WR : RD;
            RD: nextState = iMemAccessable ? CAP : waitExpired ? DONE : RD;
            CAP: nextState = weQ ? WR : DONE;
            WR: nextState = (iMemAccessable || waitExpired) ? DONE : WR;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        oBusy = state != IDLE;
        oDone = state == DONE;
        oMemRd = state == RD;
        oMemWr = state == WR;
        oAlignErr = state == DONE && alignErrQ;
        oTimeout = state == DONE && timeoutQ;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            waitCnt <= '0;
            weQ <= 1'b0;
            signedQ <= 1'b0;
            sizeQ <= '0;
            offsetQ <= '0;
            wrDataQ <= '0;
            alignErrQ <= 1'b0;
            timeoutQ <= 1'b0;
            oRdData <= '0;
            oMemAddr <= '0;
            oMemWrData <= '0;
        end else begin
            waitCnt <= (strobing && !iMemAccessable) ? waitCnt + 1'b1 : '0;
            if (state == IDLE && iReq) begin
                weQ <= iWe;
                signedQ <= iSigned;
                sizeQ <= iSize;
                offsetQ <= iAddr[1:0];
                wrDataQ <= iWrData;
                alignErrQ <= misaligned;
                timeoutQ <= 1'b0;
                oMemAddr <= {iAddr[31:2], 2'b00};
                if (iWe && iSize[1]) oMemWrData <= iWrData;
            end
            if (strobing && waitExpired) timeoutQ <= 1'b1;
            if (state == CAP) begin
                if (weQ) oMemWrData <= mergedWord;
                else oRdData <= loadValue;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench with a DataMem emulation and a byte-level reference model.
module tb_mem_access_unit;
    localparam int WM = 4;
    logic iClk = 1'b0;
    logic iRst;
    logic iReq, iWe, iSigned, iMemAccessable;
    logic [1:0] iSize;
    logic [31:0] iAddr, iWrData, iMemRdData;
    logic oBusy, oDone, oAlignErr, oTimeout, oMemRd, oMemWr;
    logic [31:0] oRdData, oMemAddr, oMemWrData;

    always #5 iClk = ~iClk;

    mem_access_unit #(.WAIT_MAX(WM)) dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iWe(iWe), .iSize(iSize), .iSigned(iSigned),
        .iAddr(iAddr), .iWrData(iWrData), .oBusy(oBusy), .oDone(oDone), .oRdData(oRdData),
        .oAlignErr(oAlignErr), .oTimeout(oTimeout), .oMemRd(oMemRd), .oMemWr(oMemWr),
        .oMemAddr(oMemAddr), .oMemWrData(oMemWrData), .iMemRdData(iMemRdData),
        .iMemAccessable(iMemAccessable)
    );

    logic [31:0] dmem [0:255];
    logic [31:0] refMem [0:255];
    logic [31:0] expRd = '0;
    logic [31:0] expAddr;
    logic both;
    int nChecks = 0, nPass = 0;
    int stallRd, stallWr, waitSoFar = 0, rdAcc, wrAcc, addrErrs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // DataMem emulation for one cycle: entered at a negedge, returns at the next negedge.
    task automatic tick();
        logic rdAccept, wrAccept;
        logic [7:0] idx;
        logic [31:0] wd;
        if (oMemRd && oMemWr) both = 1'b1;
        if (oMemRd || oMemWr) begin
            iMemAccessable = waitSoFar >= (oMemRd ? stallRd : stallWr);
            if (oMemAddr !== expAddr) addrErrs++;
        end else iMemAccessable = 1'($urandom);
        rdAccept = oMemRd && iMemAccessable;
        wrAccept = oMemWr && iMemAccessable;
        waitSoFar = ((oMemRd || oMemWr) && !iMemAccessable) ? waitSoFar + 1 : 0;
        idx = oMemAddr[9:2];
        wd = oMemWrData;
        @(posedge iClk);
        #1;
        if (wrAccept) begin dmem[idx] = wd; wrAcc++; end
        if (rdAccept) rdAcc++;
        iMemRdData = rdAccept ? dmem[idx] : $urandom;
        @(negedge iClk);
    endtask

    function automatic int phase(input int s);
        return s >= WM ? WM : s + 1;
    endfunction

    task automatic scramble();
        iReq = 1'($urandom); iWe = 1'($urandom); iSize = 2'($urandom); iSigned = 1'($urandom);
        iAddr = $urandom; iWrData = $urandom;
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input int sr, input int sw);
        int i, a, h, lat, expLat, expRdN, expWrN;
        logic [7:0] b [4];
        logic [31:0] word;
        logic isWord, mis, expTo;
        i = int'(addr[9:2]); a = int'(addr[1:0]); h = a & 2;
        word = refMem[i];
        for (int k = 0; k < 4; k++) b[k] = word[31 - 8 * k -: 8];
        isWord = sz >= 2;
        mis = (sz == 1 && addr[0]) || (isWord && a != 0);
        expTo = 1'b0; expRdN = 0; expWrN = 0;
        if (mis) expLat = 1;
        else if (we && isWord) begin
            expLat = 1 + phase(sw); expTo = sw >= WM;
            if (!expTo) begin refMem[i] = wd; expWrN = 1; end
        end else if (!we) begin
            expTo = sr >= WM;
            expLat = 1 + phase(sr) + (expTo ? 0 : 1);
            if (!expTo) begin
                expRdN = 1;
                expRd = sz == 0 ? {{24{sg & b[a][7]}}, b[a]}
                      : sz == 1 ? {{16{sg & b[h][7]}}, b[h], b[h + 1]} : word;
            end
        end else if (sr >= WM) begin
            expTo = 1'b1; expLat = 1 + WM;
        end else begin
            expRdN = 1;
            expTo = sw >= WM;
            expLat = 3 + sr + phase(sw);
            if (sz == 0) b[a] = wd[7:0];
            else begin b[h] = wd[15:8]; b[h + 1] = wd[7:0]; end
            if (!expTo) begin refMem[i] = {b[0], b[1], b[2], b[3]}; expWrN = 1; end
        end
        stallRd = sr; stallWr = sw; expAddr = {addr[31:2], 2'b00};
        rdAcc = 0; wrAcc = 0; addrErrs = 0; both = 1'b0;
        iReq = 1'b1; iWe = we; iSize = sz; iSigned = sg; iAddr = addr; iWrData = wd;
        tick();
        lat = 1;
        while (!oDone && lat < 60) begin
            scramble();
            tick();
            lat++;
        end
        check({tag, ".lat"}, lat, expLat);
        check({tag, ".busy"}, oBusy, 1'b1);
        check({tag, ".alignErr"}, oAlignErr, mis);
        check({tag, ".timeout"}, oTimeout, expTo);
        check({tag, ".rdData"}, oRdData, expRd);
        scramble();
        tick();
        iReq = 1'b0;
        check({tag, ".idleAfter"}, {oBusy, oDone}, 2'b00);
        check({tag, ".rdCount"}, rdAcc, expRdN);
        check({tag, ".wrCount"}, wrAcc, expWrN);
        check({tag, ".addr"}, addrErrs, 0);
        check({tag, ".exclusive"}, both, 1'b0);
        check({tag, ".mem"}, dmem[i], refMem[i]);
    endtask

    task automatic setWord(input logic [31:0] addr, input logic [31:0] w);
        dmem[addr[9:2]] = w;
        refMem[addr[9:2]] = w;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin dmem[k] = $urandom; refMem[k] = dmem[k]; end
        iRst = 1'b1;
        iReq = 1'b0; iWe = 1'b0; iSize = 2'd0; iSigned = 1'b0; iAddr = '0; iWrData = '0;
        iMemRdData = '0; iMemAccessable = 1'b0;
        repeat (2) @(negedge iClk);
        check("reset.ctrl", {oBusy, oDone, oAlignErr, oTimeout, oMemRd, oMemWr}, 6'd0);
        check("reset.rdData", oRdData, 32'd0);
        check("reset.memAddr", oMemAddr, 32'd0);
        check("reset.memWrData", oMemWrData, 32'd0);
        iRst = 1'b0;
        @(negedge iClk);

        setWord(32'h100, 32'h8899AABB);
        access("lb", 1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 0, 0);
        check("lb.value", oRdData, 32'hFFFFFF99);
        access("lbu", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 0);
        check("lbu.value", oRdData, 32'h000000BB);
        setWord(32'h100, 32'h1234F00D);
        access("lh", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 0, 0);
        check("lh.value", oRdData, 32'hFFFFF00D);
        access("lhMis", 1'b0, 2'd1, 1'b1, 32'h101, 32'h0, 0, 0);
        check("lhMis.held", oRdData, 32'hFFFFF00D);
        setWord(32'h100, 32'h11223344);
        access("sb", 1'b1, 2'd0, 1'b0, 32'h102, 32'h5A, 0, 0);
        check("sb.value", dmem[8'h40], 32'h11225A44);
        access("swStall", 1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF, 0, 3);
        check("swStall.value", dmem[8'h80], 32'hDEADBEEF);
        access("shTimeout", 1'b1, 2'd1, 1'b0, 32'h104, 32'hCAFE, 100, 0);
        access("swTimeout", 1'b1, 2'd3, 1'b0, 32'h108, 32'h12345678, 0, 100);
        access("lwStall", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 2, 0);
        access("shWrTimeout", 1'b1, 2'd1, 1'b0, 32'h10E, 32'hBEEF, 1, 100);

        // Reset while a word store waits in WR: strobes drop before any clock edge.
        stallWr = 100; expAddr = 32'h300; waitSoFar = 0;
        iReq = 1'b1; iWe = 1'b1; iSize = 2'd2; iSigned = 1'b0; iAddr = 32'h300; iWrData = 32'h0BADF00D;
        tick();
        iReq = 1'b0; iMemAccessable = 1'b0;
        check("rstMid.inWr", oMemWr, 1'b1);
        #2 iRst = 1'b1;
        #1;
        check("rstMid.ctrl", {oBusy, oDone, oAlignErr, oTimeout, oMemRd, oMemWr}, 6'd0);
        check("rstMid.data", {oRdData, oMemAddr, oMemWrData}, 32'd0);
        @(negedge iClk);
        iRst = 1'b0; waitSoFar = 0; expRd = '0;
        check("rstMid.mem", dmem[8'hC0], refMem[8'hC0]);
        access("afterRst", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 1, 0);

        for (int n = 0; n < 250; n++) begin
            int sr, sw;
            sr = $urandom_range(0, 19) == 0 ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3);
            sw = $urandom_range(0, 19) == 0 ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3);
            access("rand", 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, sr, sw);
        end
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
